sd_clk_sequencer: RTL and testbench
===================================

Name: sd_clk_sequencer

Overview:
- Sequences the SD card clock for the AXI SD host: programmable divider with glitch-free runtime divider changes.
- Clock stop/start under host enable and datapath back-pressure (HOLD).
- Power-up init burst: a fixed count of SD clocks per the SD spec's ≥74-clock requirement.
- Provides single-cycle CLK-domain edge strobes so the command/data engines sample and drive on SD_CLK edges without using SD_CLK as a clock.

Parameters:
- RESET_DIV, 8'd124, divider value loaded at reset (identification-rate clock).
- INIT_CYCLES, 8'd80, number of SD_CLK rising edges produced by an init burst; legal range 1..255.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-high.
- DIV_IN  in  8  requested divider; half-period = DIV+1 CLK cycles.
- DIV_WR  in  1  one-cycle strobe; captures DIV_IN into the pending register.
- CLK_EN  in  1  host enable for free-running SD clock.
- HOLD  in  1  datapath request to pause SD_CLK (FIFO full/empty).
- INIT_START  in  1  one-cycle strobe; begins init burst.
- SD_CLK  out  1  registered SD clock output.
- SD_RISE  out  1  high during first CLK cycle in which SD_CLK=1.
- SD_FALL  out  1  high during first CLK cycle in which SD_CLK=0 after a high phase.
- CUR_DIV  out  8  divider currently in use.
- DIV_BUSY  out  1  divider change pending.
- DIV_DONE  out  1  one-cycle pulse when pending divider is loaded into CUR_DIV.
- INIT_BUSY  out  1  init burst in progress.
- INIT_DONE  out  1  one-cycle pulse at end of init burst.
- CLK_RUNNING  out  1  state==RUN.

Behaviour:
- Reset (async, RST high):
  - State STOPPED; SD_CLK=0; half-period counter=0.
  - CUR_DIV=RESET_DIV; pending flag=0.
  - Edge counter=0; SD_RISE, SD_FALL, DIV_DONE, INIT_DONE, INIT_BUSY, CLK_RUNNING all 0.
  - Reset mid-burst or mid-high-phase drives SD_CLK low immediately; no recovery of the burst.
- Pending divider:
  - DIV_WR sets pend=1 and pend_val=DIV_IN.
  - DIV_WR while pend=1 overwrites pend_val; last write wins.
  - DIV_BUSY=pend.
- INIT_START:
  - Sets init=1 and clears edge counter when init=0; ignored while init=1.
  - INIT_BUSY=init.
- STOPPED state:
  - SD_CLK held 0; counter held 0.
  - Priority 1: init=1 → RUN.
  - Priority 2: pend=1 → CUR_DIV<=pend_val, pend<=0, DIV_DONE pulses; stay STOPPED for that cycle.
  - Priority 3: CLK_EN=1 and HOLD=0 → RUN.
  - DIV_WR arriving in the same cycle as a load is captured as a new pending request.
- RUN state:
  - If counter≠CUR_DIV: counter+1.
  - If counter==CUR_DIV: counter<=0 and SD_CLK toggles.
  - Each phase is exactly CUR_DIV+1 CLK cycles; full period is 2*(CUR_DIV+1). Restart from STOPPED gives a first low phase of CUR_DIV+1 cycles in RUN.
  - CUR_DIV never changes while in RUN, so a phase is never shortened.
  - Rising toggle: when init=1, edge counter increments.
- Stop decision, evaluated only on a falling toggle (SD_CLK 1→0) in RUN:
  - init=1 and edge counter==INIT_CYCLES: init<=0, INIT_DONE pulses, go STOPPED.
  - init=1, not finished: stay RUN; CLK_EN, HOLD and pend are ignored during a burst.
  - init=0 and (pend=1 or CLK_EN=0 or HOLD=1): go STOPPED.
  - Otherwise stay RUN.
  - Consequences: SD_CLK always stops low after a complete high phase; stop/pause requests made in the low phase take effect at the end of the following high phase.
  - After INIT_DONE, the normal STOPPED rules apply: pending divider first, then restart if CLK_EN=1 and HOLD=0.
- Strobes:
  - SD_RISE and SD_FALL are registered, aligned to the cycle SD_CLK first shows the new level; the stop-causing fall also produces SD_FALL.
  - SD_RISE and SD_FALL are never both high.
- Width rules:
  - Counters are 8-bit; no wrap is possible because compare-to-CUR_DIV resets the counter.
  - DIV=0 gives SD_CLK = CLK/2.
  - INIT_CYCLES=0 is illegal and is not checked.

Test Plan:
- Reset, then hold RST 5 cycles → SD_CLK=0, CUR_DIV=124, all strobes 0, CLK_RUNNING=0.
- DIV_WR with DIV_IN=1 while stopped → DIV_DONE next cycle, CUR_DIV=1. Then CLK_EN=1 → SD_CLK period 4 CLK, 2 high/2 low; SD_RISE/SD_FALL one cycle each per edge.
- Running at DIV=3, DIV_WR with DIV_IN=0 one cycle after a rising edge → current high phase completes 4 cycles, SD_CLK stops low, DIV_DONE pulses, restart at period 2; no phase shorter than 1 cycle and no high phase truncated.
- Running at DIV=2, HOLD=1 asserted in the low phase → next rise and a full 3-cycle high phase occur, then SD_CLK held low. HOLD=0 → low phase of ≥3 cycles before the next rise.
- CLK_EN=0, DIV=0, INIT_START pulse → exactly 80 SD_RISE pulses, INIT_DONE after the 80th fall, INIT_BUSY 0 afterwards, SD_CLK low. A DIV_WR mid-burst is applied only after INIT_DONE.
- RST asserted while SD_CLK=1 mid-burst → SD_CLK=0 and INIT_BUSY=0 immediately; CUR_DIV=124.

Source files
------------

// File: rtl/sd_clk_sequencer.sv
// SD card clock sequencer: programmable half-period divider, stop/start on
// host enable or datapath HOLD, power-up init burst, and CLK-domain edge strobes.
module sd_clk_sequencer #(
  parameter logic [7:0] RESET_DIV   = 8'd124,
  parameter logic [7:0] INIT_CYCLES = 8'd80
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] DIV_IN,
  input  logic       DIV_WR,
  input  logic       CLK_EN,
  input  logic       HOLD,
  input  logic       INIT_START,
  output logic       SD_CLK,
  output logic       SD_RISE,
  output logic       SD_FALL,
  output logic [7:0] CUR_DIV,
  output logic       DIV_BUSY,
  output logic       DIV_DONE,
  output logic       INIT_BUSY,
  output logic       INIT_DONE,
  output logic       CLK_RUNNING
);

  typedef enum logic {ST_STOPPED = 1'b0, ST_RUN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       sd_clk_q, sd_clk_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cur_div_q, cur_div_d;
  logic       pend_q, pend_d;
  logic [7:0] pend_val_q, pend_val_d;
  logic       init_q, init_d;
  logic [7:0] edge_q, edge_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       div_done_q, div_done_d;
  logic       init_done_q, init_done_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_STOPPED;
      sd_clk_q    <= 1'b0;
      cnt_q       <= 8'd0;
      cur_div_q   <= RESET_DIV;
      pend_q      <= 1'b0;
      pend_val_q  <= 8'd0;
      init_q      <= 1'b0;
      edge_q      <= 8'd0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      div_done_q  <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sd_clk_q    <= sd_clk_d;
      cnt_q       <= cnt_d;
      cur_div_q   <= cur_div_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      init_q      <= init_d;
      edge_q      <= edge_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      div_done_q  <= div_done_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sd_clk_d    = sd_clk_q;
    cnt_d       = cnt_q;
    cur_div_d   = cur_div_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;
    init_d      = init_q;
    edge_d      = edge_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    div_done_d  = 1'b0;
    init_done_d = 1'b0;

    if (DIV_WR) begin
      pend_d     = 1'b1;
      pend_val_d = DIV_IN;
    end
    if (INIT_START && !init_q) begin
      init_d = 1'b1;
      edge_d = 8'd0;
    end

    case (state_q)
      ST_STOPPED: begin
        sd_clk_d = 1'b0;
        cnt_d    = 8'd0;
        if (init_q) begin
          state_d = ST_RUN;
        end else if (pend_q) begin
          // A write landing on the load cycle stays pending for the next load.
          cur_div_d  = pend_val_q;
          pend_d     = DIV_WR;
          div_done_d = 1'b1;
        end else if (CLK_EN && !HOLD) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        if (cnt_q != cur_div_q) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d    = 8'd0;
          sd_clk_d = ~sd_clk_q;
          if (!sd_clk_q) begin
            rise_d = 1'b1;
            if (init_q) edge_d = edge_q + 8'd1;
          end else begin
            // Stops are only taken here, so SD_CLK always parks low after a full high phase.
            fall_d = 1'b1;
            if (init_q) begin
              if (edge_q == INIT_CYCLES) begin
                init_d      = 1'b0;
                init_done_d = 1'b1;
                state_d     = ST_STOPPED;
              end
            end else if (pend_q || !CLK_EN || HOLD) begin
              state_d = ST_STOPPED;
            end
          end
        end
      end
    endcase
  end

  // Strobes are registered alongside SD_CLK, so each is high exactly in the
  // first CLK cycle that shows the new SD_CLK level.
  always_comb begin
    SD_CLK      = sd_clk_q;
    SD_RISE     = rise_q;
    SD_FALL     = fall_q;
    CUR_DIV     = cur_div_q;
    DIV_BUSY    = pend_q;
    DIV_DONE    = div_done_q;
    INIT_BUSY   = init_q;
    INIT_DONE   = init_done_q;
    CLK_RUNNING = (state_q == ST_RUN);
  end

endmodule

// File: tb/tb_sd_clk_sequencer.sv
// Bench for sd_clk_sequencer: directed scenarios plus random traffic, all
// checked every cycle against a phase/transaction-level reference model.
module tb_sd_clk_sequencer;

  localparam logic [7:0] RDIV = 8'd124;
  localparam logic [7:0] ICYC = 8'd80;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] DIV_IN = 8'd0;
  logic       DIV_WR = 1'b0;
  logic       CLK_EN = 1'b0;
  logic       HOLD = 1'b0;
  logic       INIT_START = 1'b0;
  logic       SD_CLK, SD_RISE, SD_FALL, DIV_BUSY, DIV_DONE;
  logic       INIT_BUSY, INIT_DONE, CLK_RUNNING;
  logic [7:0] CUR_DIV;

  int n_chk = 0;
  int n_fail = 0;

  sd_clk_sequencer #(.RESET_DIV(RDIV), .INIT_CYCLES(ICYC)) dut (
    .CLK(CLK), .RST(RST), .DIV_IN(DIV_IN), .DIV_WR(DIV_WR), .CLK_EN(CLK_EN),
    .HOLD(HOLD), .INIT_START(INIT_START), .SD_CLK(SD_CLK), .SD_RISE(SD_RISE),
    .SD_FALL(SD_FALL), .CUR_DIV(CUR_DIV), .DIV_BUSY(DIV_BUSY), .DIV_DONE(DIV_DONE),
    .INIT_BUSY(INIT_BUSY), .INIT_DONE(INIT_DONE), .CLK_RUNNING(CLK_RUNNING)
  );

  // clock / reset sampling
  always #5 CLK = ~CLK;
  logic rst_pe = 1'b1;
  always @(posedge CLK) rst_pe <= RST;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // reference model: divider slot, init burst, phase lengths
  logic [7:0] cur_m, pend_val_m;
  logic       pend_m, init_m, prev_sd, prev_run;
  int         rise_cnt, high_len, low_len;
  logic       nxt_en, nxt_hold, nxt_wr, nxt_st;
  logic [7:0] nxt_wrv;
  logic       init_b, pend_b, rise_e, fall_e, done_e, stop_e;

  always @(negedge CLK) begin
    if (RST || rst_pe) begin
      cur_m = RDIV; pend_m = 1'b0; pend_val_m = 8'd0; init_m = 1'b0;
      rise_cnt = 0; high_len = 0; low_len = 0; prev_sd = 1'b0; prev_run = 1'b0;
    end else begin
      init_b = init_m;
      pend_b = pend_m;
      rise_e = SD_CLK && !prev_sd;
      fall_e = !SD_CLK && prev_sd;
      check("sd_rise", 32'(SD_RISE), 32'(rise_e));
      check("sd_fall", 32'(SD_FALL), 32'(fall_e));
      check("stopped_low", 32'(SD_CLK && !CLK_RUNNING), 32'd0);
      if (rise_e) begin
        check("low_len", 32'(low_len), 32'(cur_m) + 32'd1);
        low_len = 0;
        high_len = 0;
        if (init_b) rise_cnt++;
      end
      if (SD_CLK) high_len++;
      if (fall_e) begin
        check("high_len", 32'(high_len), 32'(cur_m) + 32'd1);
        low_len = 0;
      end
      if (!SD_CLK && CLK_RUNNING) low_len++;
      if (!prev_run) begin
        check("div_done", 32'(DIV_DONE), 32'(!init_b && pend_b));
        check("restart", 32'(CLK_RUNNING), 32'(init_b || (!pend_b && nxt_en && !nxt_hold)));
        check("init_done", 32'(INIT_DONE), 32'd0);
        if (!init_b && pend_b) begin
          cur_m = pend_val_m;
          pend_m = 1'b0;
        end
      end else begin
        check("div_done", 32'(DIV_DONE), 32'd0);
        if (fall_e) begin
          done_e = init_b && (rise_cnt == int'(ICYC));
          stop_e = init_b ? done_e : (pend_b || !nxt_en || nxt_hold);
          check("init_done", 32'(INIT_DONE), 32'(done_e));
          check("stop", 32'(CLK_RUNNING), 32'(!stop_e));
          if (done_e) init_m = 1'b0;
        end else begin
          check("init_done", 32'(INIT_DONE), 32'd0);
          check("no_stop", 32'(CLK_RUNNING), 32'd1);
        end
      end
      if (nxt_wr) begin
        pend_m = 1'b1;
        pend_val_m = nxt_wrv;
      end
      if (nxt_st && !init_b) begin
        init_m = 1'b1;
        rise_cnt = 0;
      end
      check("div_busy", 32'(DIV_BUSY), 32'(pend_m));
      check("cur_div", 32'(CUR_DIV), 32'(cur_m));
      check("init_busy", 32'(INIT_BUSY), 32'(init_m));
      prev_sd = SD_CLK;
      prev_run = CLK_RUNNING;
    end
    nxt_en = CLK_EN; nxt_hold = HOLD; nxt_wr = DIV_WR; nxt_wrv = DIV_IN; nxt_st = INIT_START;
  end

  // driver tasks
  task automatic drive_div(input logic [7:0] v);
    @(posedge CLK) #1;
    DIV_IN = v;
    DIV_WR = 1'b1;
    @(posedge CLK) #1;
    DIV_WR = 1'b0;
  endtask

  // 0:SD_RISE 1:SD_FALL 2:DIV_DONE 3:INIT_DONE 4:SD_CLK high 5:idle (stopped, no burst)
  task automatic wait_for(input int which, input int budget, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge CLK);
      case (which)
        0: hit = SD_RISE;
        1: hit = SD_FALL;
        2: hit = DIV_DONE;
        3: hit = INIT_DONE;
        4: hit = SD_CLK;
        default: hit = !CLK_RUNNING && !INIT_BUSY;
      endcase
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  int pat_sd[4]   = '{1, 0, 0, 1};
  int pat_fall[4] = '{0, 1, 0, 0};
  int rises;
  logic done_seen;

  initial begin
    // reset values
    repeat (5) @(negedge CLK);
    check("rst_sd_clk", 32'(SD_CLK), 32'd0);
    check("rst_cur_div", 32'(CUR_DIV), 32'd124);
    check("rst_strobes", 32'({SD_RISE, SD_FALL, DIV_DONE, INIT_DONE}), 32'd0);
    check("rst_running", 32'(CLK_RUNNING), 32'd0);
    check("rst_busy", 32'({DIV_BUSY, INIT_BUSY}), 32'd0);
    @(posedge CLK) #1;
    RST = 1'b0;

    // divider load while stopped, then free-run at period 4
    drive_div(8'd1);
    @(negedge CLK);
    check("pend_set", 32'(DIV_BUSY), 32'd1);
    @(negedge CLK);
    check("load_done", 32'(DIV_DONE), 32'd1);
    check("load_cur", 32'(CUR_DIV), 32'd1);
    @(posedge CLK) #1;
    CLK_EN = 1'b1;
    wait_for(0, 20, "first_rise");
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("div1_sd", 32'(SD_CLK), 32'(pat_sd[i]));
      check("div1_fall", 32'(SD_FALL), 32'(pat_fall[i]));
    end
    repeat (20) @(posedge CLK);

    // runtime change 1 -> 3, then 3 -> 0 written just after a rise
    drive_div(8'd3);
    wait_for(2, 50, "div3_done");
    check("div3_cur", 32'(CUR_DIV), 32'd3);
    repeat (30) @(posedge CLK);
    wait_for(0, 20, "div3_rise");
    drive_div(8'd0);
    wait_for(1, 20, "div3_fall");
    check("div0_stopped", 32'(CLK_RUNNING), 32'd0);
    @(negedge CLK);
    check("div0_done", 32'(DIV_DONE), 32'd1);
    check("div0_cur", 32'(CUR_DIV), 32'd0);
    repeat (20) @(posedge CLK);

    // HOLD raised in the low phase at DIV=2
    drive_div(8'd2);
    wait_for(2, 50, "div2_done");
    repeat (20) @(posedge CLK);
    wait_for(1, 20, "hold_low_phase");
    @(posedge CLK) #1;
    HOLD = 1'b1;
    wait_for(0, 10, "hold_rise");
    wait_for(1, 10, "hold_fall");
    check("hold_stopped", 32'(CLK_RUNNING), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("hold_sd_low", 32'(SD_CLK), 32'd0);
    end
    @(posedge CLK) #1;
    HOLD = 1'b0;
    repeat (30) @(posedge CLK);

    // init burst at DIV=0 with a divider write mid-burst
    @(posedge CLK) #1;
    CLK_EN = 1'b0;
    drive_div(8'd0);
    wait_for(2, 50, "pre_init_done");
    check("pre_init_cur", 32'(CUR_DIV), 32'd0);
    @(posedge CLK) #1;
    INIT_START = 1'b1;
    @(posedge CLK) #1;
    INIT_START = 1'b0;
    rises = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 1000 && !done_seen; i++) begin
      @(posedge CLK) #1;
      DIV_WR = (i == 30);
      DIV_IN = 8'd5;
      @(negedge CLK);
      if (SD_RISE) rises++;
      done_seen = INIT_DONE;
    end
    check("init_done_seen", 32'(done_seen), 32'd1);
    check("init_rises", 32'(rises), 32'(ICYC));
    check("init_sd_low", 32'(SD_CLK), 32'd0);
    check("init_div_held", 32'(CUR_DIV), 32'd0);
    @(negedge CLK);
    check("init_busy_clr", 32'(INIT_BUSY), 32'd0);
    check("post_init_load", 32'(DIV_DONE), 32'd1);
    check("post_init_cur", 32'(CUR_DIV), 32'd5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(posedge CLK) #1;
      DIV_WR = ($urandom_range(0, 29) == 0);
      DIV_IN = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) CLK_EN = ~CLK_EN;
      HOLD = ($urandom_range(0, 9) == 0);
      INIT_START = ($urandom_range(0, 799) == 0);
    end
    @(posedge CLK) #1;
    DIV_WR = 1'b0; CLK_EN = 1'b0; HOLD = 1'b0; INIT_START = 1'b0;
    wait_for(5, 2000, "rand_quiesce");

    // reset in the middle of a burst high phase
    drive_div(8'd3);
    repeat (5) @(posedge CLK);
    #1 INIT_START = 1'b1;
    @(posedge CLK) #1;
    INIT_START = 1'b0;
    repeat (40) @(posedge CLK);
    wait_for(4, 20, "burst_high");
    #2 RST = 1'b1;
    #1;
    check("arst_sd_clk", 32'(SD_CLK), 32'd0);
    check("arst_init_busy", 32'(INIT_BUSY), 32'd0);
    check("arst_cur_div", 32'(CUR_DIV), 32'd124);
    check("arst_running", 32'(CLK_RUNNING), 32'd0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (10) @(posedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
